// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb_pkg
// Description : Shared CPU definitions for the instruction-memory arbiter:
//               arbiter state encoding, default imem address width and a
//               saturating 4-bit counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

    // Default word-address width of the shared instruction memory.
    localparam int IMEM_ADDR_W = 8;

    // Arbiter states: who owns the imem port this cycle.
    typedef logic [1:0] arb_state_t;
    localparam logic [1:0] S_FETCH = 2'd0;  // fetch owns the port
    localparam logic [1:0] S_LOAD  = 2'd1;  // loader owns the port
    localparam logic [1:0] S_DRAIN = 2'd2;  // port idle, flush pending

    // Increment a 4-bit counter, holding at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] val);
        return (val == 4'hF) ? val : val + 4'd1;
    endfunction

endpackage : imem_arb_pkg
`default_nettype wire

// File: rtl/imem_arb.sv
`default_nettype none
// ============================================================================
// Module      : imem_arb
// Description : Arbitrates the single instruction-memory port between the
//               fetch unit (reads) and the program loader (writes). The
//               loader wins contention; when a load burst ends a one-cycle
//               drain slot raises arb_if__flush so fetch discards stale
//               instructions.
//               Optional feature macro IMEM_ARB_FAIR_EN: when defined, fetch
//               is given one slot after every MAX_BURST consecutive loader
//               writes. When undefined the loader has strict priority.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arb
    import imem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int ADDR_W    = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_arb__req,
    input  logic [ADDR_W-1:0] if_arb__addr,
    input  logic              ld_arb__req,
    input  logic [ADDR_W-1:0] ld_arb__addr,
    input  logic [31:0]       ld_arb__wdata,
    output logic              arb_if__gnt,
    output logic              arb_ld__gnt,
    output logic              arb_if__stall,
    output logic              arb_if__flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata
);

    // Reject out-of-range burst limits at elaboration.
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_max_burst_check
        $error("imem_arb: MAX_BURST must be in 1..15");
    end

    arb_state_t state_q;
    arb_state_t state_d;
    logic       flush_q;
    logic       flush_d;
    logic       if_gnt;
    logic       ld_gnt;

`ifdef IMEM_ARB_FAIR_EN
    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

    logic [3:0] burst_cnt_q;
    logic [3:0] burst_cnt_d;
`endif

    // Next-state, grant and flush-request decode from state and requests.
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        if_gnt  = 1'b0;
        ld_gnt  = 1'b0;
`ifdef IMEM_ARB_FAIR_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                // Loader wins a simultaneous request.
                if (ld_arb__req) begin
                    ld_gnt  = 1'b1;
                    state_d = S_LOAD;
`ifdef IMEM_ARB_FAIR_EN
                    burst_cnt_d = 4'd1;
`endif
                end else begin
                    if_gnt = if_arb__req;
                end
            end
            S_LOAD: begin
                if (!ld_arb__req) begin
                    // Burst over: idle the port one cycle and flag the flush.
                    state_d = S_DRAIN;
                    flush_d = 1'b1;
                end else begin
`ifdef IMEM_ARB_FAIR_EN
                    if (burst_cnt_q == c_max_burst) begin
                        // Fairness slot; the loader reclaims it if fetch is idle.
                        if (if_arb__req) begin
                            if_gnt = 1'b1;
                        end else begin
                            ld_gnt = 1'b1;
                        end
                        burst_cnt_d = 4'd0;
                    end else begin
                        ld_gnt      = 1'b1;
                        burst_cnt_d = sat_inc4(burst_cnt_q);
                    end
`else
                    ld_gnt = 1'b1;
`endif
                end
            end
            S_DRAIN: begin
                // Fetch stays blocked; a returning loader may start at once.
                if (ld_arb__req) begin
                    ld_gnt  = 1'b1;
                    state_d = S_LOAD;
`ifdef IMEM_ARB_FAIR_EN
                    burst_cnt_d = 4'd1;
`endif
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Nothing is issued to imem while reset is asserted.
        if (rst) begin
            if_gnt = 1'b0;
            ld_gnt = 1'b0;
        end
    end

    // State, flush pulse and burst counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            flush_q <= 1'b0;
`ifdef IMEM_ARB_FAIR_EN
            burst_cnt_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
`ifdef IMEM_ARB_FAIR_EN
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    // Route the granted requester onto the imem port.
    always_comb begin
        mem_addr  = if_arb__addr;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = 32'd0;
        if (ld_gnt) begin
            mem_addr  = ld_arb__addr;
            mem_write = 1'b1;
            mem_wdata = ld_arb__wdata;
        end else if (if_gnt) begin
            mem_read = 1'b1;
        end
    end

    assign arb_if__gnt   = if_gnt;
    assign arb_ld__gnt   = ld_gnt;
    assign arb_if__stall = if_arb__req & ~if_gnt;
    assign arb_if__flush = flush_q;

endmodule : imem_arb
`default_nettype wire
